// File: rtl/mac_clk_pkg.sv
// Shared constants for the Mac clock-enable sequencer: FSM encodings,
// E-clock timing and phase decode values.
package mac_clk_pkg;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [ST_W-1:0] ST_HOLD      = 2'd1;
  localparam logic [ST_W-1:0] ST_RUN       = 2'd2;

  localparam int unsigned PH_W = 2;
  localparam logic [PH_W-1:0] PH_CPU_P = 2'd1;
  localparam logic [PH_W-1:0] PH_CPU_N = 2'd3;

  localparam int unsigned E_PERIOD     = 10;
  localparam int unsigned E_HIGH_START = 6;
  localparam int unsigned ECNT_W       = 4;

  localparam int unsigned HOLD_CNT_W = 16;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; only the last stage is exported.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mac_clken_seq.sv
// Mac clock-enable sequencer: qualifies PLL lock, holds the core in reset,
// then generates pixel, CPU and 68000 E-clock enables from a single clk_sys.
module mac_clken_seq
  import mac_clk_pkg::*;
#(
  parameter int unsigned RESET_HOLD  = 1024,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pll_locked,
  output logic core_reset,
  output logic ready,
  output logic pix_ce,
  output logic cpu_ce_p,
  output logic cpu_ce_n,
  output logic e_clk,
  output logic e_ce
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RESET_HOLD - 1);
  localparam logic [ECNT_W-1:0]     ECNT_LAST = ECNT_W'(E_PERIOD - 1);
  localparam logic [ECNT_W-1:0]     ECNT_HIGH = ECNT_W'(E_HIGH_START);

  logic                  lock_s;
  logic [ST_W-1:0]       state_q, state_d;
  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [PH_W-1:0]       ph_q, ph_d;
  logic [ECNT_W-1:0]     ecnt_q, ecnt_d;
  logic                  core_reset_q, core_reset_d;
  logic                  ready_q, ready_d;
  logic                  pix_ce_q, pix_ce_d;
  logic                  cpu_ce_p_q, cpu_ce_p_d;
  logic                  cpu_ce_n_q, cpu_ce_n_d;
  logic                  e_clk_q, e_clk_d;
  logic                  e_ce_q, e_ce_d;
  logic                  run_d;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (clk_sys),
    .rst_i (reset),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  // Lock-loss checks come first in HOLD so they win over the RUN transition.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  // Outputs are decoded from next-state values so each register lines up
  // with the cycle it describes; leaving RUN clears everything at once.
  always_comb begin
    run_d        = (state_d == ST_RUN);
    ph_d         = '0;
    ecnt_d       = '0;
    core_reset_d = !run_d;
    ready_d      = run_d;
    pix_ce_d     = 1'b0;
    cpu_ce_p_d   = 1'b0;
    cpu_ce_n_d   = 1'b0;
    e_clk_d      = 1'b0;
    e_ce_d       = 1'b0;
    if (run_d) begin
      if (state_q == ST_RUN) begin
        ph_d = ph_q + PH_W'(1);
      end
      ecnt_d = ecnt_q;
      if (cpu_ce_n_q) begin
        ecnt_d = (ecnt_q == ECNT_LAST) ? '0 : ecnt_q + ECNT_W'(1);
      end
      pix_ce_d   = ph_d[0];
      cpu_ce_p_d = (ph_d == PH_CPU_P);
      cpu_ce_n_d = (ph_d == PH_CPU_N);
      e_clk_d    = (ecnt_d >= ECNT_HIGH);
      e_ce_d     = cpu_ce_n_d && (ecnt_d == ECNT_LAST);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_WAIT_LOCK;
      hold_cnt_q   <= '0;
      ph_q         <= '0;
      ecnt_q       <= '0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      pix_ce_q     <= 1'b0;
      cpu_ce_p_q   <= 1'b0;
      cpu_ce_n_q   <= 1'b0;
      e_clk_q      <= 1'b0;
      e_ce_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      ph_q         <= ph_d;
      ecnt_q       <= ecnt_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
      pix_ce_q     <= pix_ce_d;
      cpu_ce_p_q   <= cpu_ce_p_d;
      cpu_ce_n_q   <= cpu_ce_n_d;
      e_clk_q      <= e_clk_d;
      e_ce_q       <= e_ce_d;
    end
  end

  assign core_reset = core_reset_q;
  assign ready      = ready_q;
  assign pix_ce     = pix_ce_q;
  assign cpu_ce_p   = cpu_ce_p_q;
  assign cpu_ce_n   = cpu_ce_n_q;
  assign e_clk      = e_clk_q;
  assign e_ce       = e_ce_q;

endmodule

// File: tb/tb_mac_clken_seq.sv
// Directed bench for mac_clken_seq with RESET_HOLD=16, SYNC_STAGES=2.
module tb_mac_clken_seq;

  localparam int unsigned HOLD = 16;
  localparam int unsigned SYNC = 2;
  localparam int LOCK_LAT = SYNC + 1 + HOLD;

  logic clk_sys = 1'b0;
  logic reset, pll_locked;
  logic core_reset, ready, pix_ce, cpu_ce_p, cpu_ce_n, e_clk, e_ce;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  mac_clken_seq #(
    .RESET_HOLD  (HOLD),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pll_locked (pll_locked),
    .core_reset (core_reset),
    .ready      (ready),
    .pix_ce     (pix_ce),
    .cpu_ce_p   (cpu_ce_p),
    .cpu_ce_n   (cpu_ce_n),
    .e_clk      (e_clk),
    .e_ce       (e_ce)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Drive lock now (just after an edge) and count edges until core_reset falls.
  task automatic lock_latency(output int n);
    pll_locked = 1'b1;
    n = 0;
    while (n < 200) begin
      step();
      n++;
      if (!core_reset) break;
    end
  endtask

  int n, ens, rdy_hi, crst_lo;
  int pix_n, p_n, n_n, e_n, first_e, first_p, last_p, viol, elow, ehigh, ece_bad;
  logic prev_ece;
  logic e_at39, e_at40;

  initial begin
    reset = 1'b1;
    pll_locked = 1'b0;
    repeat (3) step();
    chk("rst_core_reset", int'(core_reset), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_enables", int'({pix_ce, cpu_ce_p, cpu_ce_n, e_clk, e_ce}), 0);

    reset = 1'b0;
    repeat (5) step();
    chk("nolock_core_reset", int'(core_reset), 1);

    lock_latency(n);
    chk("lock_latency", n, LOCK_LAT);
    chk("lock_ready", int'(ready), 1);

    // Cycle 0 is the first RUN cycle, currently being sampled.
    pix_n = 0; p_n = 0; n_n = 0; e_n = 0; first_e = -1; first_p = -1; last_p = -100;
    viol = 0; elow = 0; ehigh = 0; ece_bad = 0; prev_ece = 1'b0;
    e_at39 = 1'b0; e_at40 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (pix_ce) pix_n++;
      if (cpu_ce_p) begin
        p_n++;
        if (first_p < 0) first_p = i;
        last_p = i;
      end
      if (cpu_ce_n) begin
        n_n++;
        if (i - last_p != 2) viol++;
      end
      if (e_ce) begin
        e_n++;
        if (first_e < 0) first_e = i;
        if (!e_clk) ece_bad++;
      end
      if (prev_ece && e_clk) ece_bad++;
      prev_ece = e_ce;
      if (i < 40) begin
        if (e_clk) ehigh++;
        else if (ehigh == 0) elow++;
      end
      if (i == 39) e_at39 = e_clk;
      if (i == 40) e_at40 = e_clk;
      step();
    end
    chk("pix_ce_count", pix_n, 200);
    chk("cpu_ce_p_count", p_n, 100);
    chk("cpu_ce_n_count", n_n, 100);
    chk("first_cpu_ce_p", first_p, 1);
    chk("ce_n_after_ce_p", viol, 0);
    chk("e_ce_count", e_n, 10);
    chk("first_e_ce", first_e, 39);
    chk("e_clk_low_cycles", elow, 24);
    chk("e_clk_high_cycles", ehigh, 16);
    chk("e_clk_at_39", int'(e_at39), 1);
    chk("e_clk_at_40", int'(e_at40), 0);
    chk("e_ce_on_fall", ece_bad, 0);

    // Lock glitch driven during a ph=2 cycle.
    n = 0;
    while (!cpu_ce_p && n < 10) begin
      step();
      n++;
    end
    chk("find_cpu_ce_p", int'(cpu_ce_p), 1);
    step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    n = 1;
    ens = 0;
    while (n < 200) begin
      step();
      n++;
      if (n == 3) chk("drop_core_reset", int'(core_reset), 1);
      if (n >= 3 && !core_reset) break;
      if (core_reset) ens += int'(pix_ce) + int'(cpu_ce_p) + int'(cpu_ce_n)
                             + int'(e_clk) + int'(e_ce);
    end
    chk("drop_relock_cycles", n, 20);
    chk("drop_enables_quiet", ens, 0);

    // Lock chattering every 5 cycles never completes the hold.
    pll_locked = 1'b0;
    repeat (5) step();
    rdy_hi = 0;
    crst_lo = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 5 == 0) pll_locked = ~pll_locked;
      step();
      if (ready) rdy_hi++;
      if (!core_reset) crst_lo++;
    end
    chk("toggle_ready", rdy_hi, 0);
    chk("toggle_core_reset", crst_lo, 0);

    // Reset landing on the last HOLD cycle beats the RUN transition.
    pll_locked = 1'b0;
    repeat (5) step();
    pll_locked = 1'b1;
    repeat (LOCK_LAT - 1) step();
    chk("final_hold_core_reset", int'(core_reset), 1);
    reset = 1'b1;
    step();
    chk("reset_win_core_reset", int'(core_reset), 1);
    chk("reset_win_ready", int'(ready), 0);
    reset = 1'b0;
    lock_latency(n);
    chk("relock_after_reset", n, LOCK_LAT);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
